// File: rtl/mult_div_unit.sv
// Execute-stage HI/LO unit: multi-cycle MULT/MULTU, 32-step restoring DIV/DIVU,
// single-cycle MTHI/MTLO, and ownership of the architectural HI/LO registers.
module mult_div_unit #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ITR_W = 5;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, state_d;
  logic               accept;
  logic [CNT_W-1:0]   cnt;
  logic [ITR_W-1:0]   iter;
  logic [2*XLEN-1:0]  prod;
  logic [XLEN-1:0]    dq;        // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]    rem;
  logic [XLEN-1:0]    divisor;
  logic               q_neg, r_neg, div_zero;

  logic               op_signed;
  logic [2*XLEN-1:0]  mul_a, mul_b, product;
  logic [XLEN-1:0]    a_abs, b_abs;
  logic [XLEN:0]      rem_sh, rem_diff;
  logic [XLEN-1:0]    q_fix, r_fix;

  // Operand conditioning shared by multiply and divide accept
  always_comb begin
    op_signed = ~op_i[0];
    mul_a     = {{XLEN{op_signed & src_a_i[XLEN-1]}}, src_a_i};
    mul_b     = {{XLEN{op_signed & src_b_i[XLEN-1]}}, src_b_i};
    product   = mul_a * mul_b;
    a_abs     = (op_signed && src_a_i[XLEN-1]) ? -src_a_i : src_a_i;
    b_abs     = (op_signed && src_b_i[XLEN-1]) ? -src_b_i : src_b_i;
  end

  // One restoring step on the 33-bit partial remainder, plus final sign fix-up
  always_comb begin
    rem_sh   = {rem, dq[XLEN-1]};
    rem_diff = rem_sh - {1'b0, divisor};
    q_fix    = div_zero ? '1 : (q_neg ? -dq : dq);
    r_fix    = r_neg ? -rem : rem;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !flush_i) begin
          accept = 1'b1;
          case (op_i)
            OP_MULT, OP_MULTU: state_d = MUL;
            OP_DIV,  OP_DIVU:  state_d = DIV;
            default:           state_d = IDLE;
          endcase
        end
      end
      MUL:     if (flush_i || cnt == '0) state_d = IDLE;
      DIV:     if (flush_i) state_d = IDLE;
               else if (iter == ITR_W'(XLEN - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_d;
  end

  // Datapath: HI/LO only move on MT* accept or an unflushed completion edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_o   <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
      cnt      <= '0;
      iter     <= '0;
      prod     <= '0;
      dq       <= '0;
      rem      <= '0;
      divisor  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op_i)
              OP_MULT, OP_MULTU: begin
                prod <= product;
                cnt  <= CNT_W'(MUL_LATENCY - 1);
              end
              OP_DIV, OP_DIVU: begin
                dq       <= a_abs;
                divisor  <= b_abs;
                rem      <= '0;
                iter     <= '0;
                q_neg    <= op_signed & (src_a_i[XLEN-1] ^ src_b_i[XLEN-1]);
                r_neg    <= op_signed & src_a_i[XLEN-1];
                div_zero <= (src_b_i == '0);
              end
              OP_MTHI: hi_o <= src_a_i;
              OP_MTLO: lo_o <= src_a_i;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (!flush_i) begin
            if (cnt == '0) begin
              {hi_o, lo_o} <= prod;
              done_o       <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        DIV: begin
          if (!flush_i) begin
            if (!rem_diff[XLEN]) begin
              rem <= rem_diff[XLEN-1:0];
              dq  <= {dq[XLEN-2:0], 1'b1};
            end else begin
              rem <= rem_sh[XLEN-1:0];
              dq  <= {dq[XLEN-2:0], 1'b0};
            end
            iter <= iter + ITR_W'(1);
          end
        end
        FIX: begin
          if (!flush_i) begin
            lo_o   <= q_fix;
            hi_o   <= r_fix;
            done_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: constant vector table, randomized ops
// against an arithmetic reference model, and hand-written flush/reset/back-to-back cases.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy3, done3, busy5, done5;
  logic [31:0] hi3, lo3, hi5, lo5;

  int tests = 0;
  int fails = 0;
  logic [31:0] mhi, mlo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vt[10];

  mult_div_unit #(.MUL_LATENCY(3)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .src_a_i(a), .src_b_i(b),
    .flush_i(flush), .busy_o(busy3), .done_o(done3), .hi_o(hi3), .lo_o(lo3)
  );

  mult_div_unit #(.MUL_LATENCY(5)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .src_a_i(a), .src_b_i(b),
    .flush_i(flush), .busy_o(busy5), .done_o(done5), .hi_o(hi5), .lo_o(lo5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: returns {hi,lo} after the op, given the current {hi,lo}
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] cur);
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint q, r;
    logic [63:0] ux = {32'b0, x};
    logic [63:0] uy = {32'b0, y};
    case (o)
      3'd0: return 64'(sx * sy);
      3'd1: return ux * uy;
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      3'd4: return {x, cur[31:0]};
      3'd5: return {cur[63:32], x};
      default: return cur;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Issue one op and check latency, HI/LO stability, done pulse and result
  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [63:0] e, input string name);
    int lat, n;
    bit stable;
    lat = (o < 3'd2) ? 3 : (o < 3'd4) ? 33 : 0;
    issue(o, x, y);
    if (lat == 0) begin
      chk({name, "_busy"}, 64'(busy3), 64'd0);
      chk({name, "_done"}, 64'(done3), 64'd0);
      chk({name, "_hilo"}, {hi3, lo3}, e);
    end else begin
      n = 0;
      stable = 1'b1;
      while (busy3 && n < 200) begin
        n++;
        if ({hi3, lo3} !== {mhi, mlo}) stable = 1'b0;
        @(negedge clk);
      end
      chk({name, "_lat"}, 64'(n), 64'(lat));
      chk({name, "_stable"}, 64'(stable), 64'd1);
      chk({name, "_done"}, 64'(done3), 64'd1);
      chk({name, "_hilo"}, {hi3, lo3}, e);
      @(negedge clk);
      chk({name, "_done_once"}, 64'(done3), 64'd0);
    end
    {mhi, mlo} = e;
  endtask

  initial begin
    int n;
    logic [2:0]  ro;
    logic [31:0] rx, ry;

    vt[0] = '{3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vt[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vt[2] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vt[3] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[4] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    vt[5] = '{3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vt[6] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[7] = '{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vt[8] = '{3'd4, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
    vt[9] = '{3'd5, 32'h0000_0055, 32'd0,         32'h0000_1234, 32'h0000_0055};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    mhi = '0; mlo = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 64'(busy3), 64'd0);
    chk("reset_done", 64'(done3), 64'd0);
    chk("reset_hilo", {hi3, lo3}, 64'd0);

    // MUL_LATENCY=5 instance: busy for 5 cycles, result at accept+5
    issue(3'd0, 32'd6, 32'd7);
    n = 0;
    while (busy5 && n < 50) begin n++; @(negedge clk); end
    chk("lat5_busy_cycles", 64'(n), 64'd5);
    chk("lat5_done", 64'(done5), 64'd1);
    chk("lat5_hilo", {hi5, lo5}, 64'd42);
    @(negedge clk);
    {mhi, mlo} = 64'd42;

    // Reset two cycles into a MULT aborts at once and clears HI/LO
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    @(negedge clk);
    chk("rstmid_busy_before", 64'(busy5), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_busy5", 64'(busy5), 64'd0);
    chk("rstmid_busy3", 64'(busy3), 64'd0);
    chk("rstmid_hilo5", {hi5, lo5}, 64'd0);
    chk("rstmid_hilo3", {hi3, lo3}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    {mhi, mlo} = '0;

    for (int i = 0; i < 10; i++)
      run(vt[i].op, vt[i].a, vt[i].b, {vt[i].ehi, vt[i].elo}, $sformatf("vec%0d", i));

    // Flush ten cycles into a DIV
    run(3'd4, 32'h1234, 32'd0, {32'h1234, mlo}, "mthi_pre");
    issue(3'd2, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush10_busy", 64'(busy3), 64'd0);
    chk("flush10_done", 64'(done3), 64'd0);
    chk("flush10_hilo", {hi3, lo3}, {mhi, mlo});
    @(negedge clk);
    chk("flush10_done_after", 64'(done3), 64'd0);

    // Flush coinciding with the completion edge
    issue(3'd2, 32'd1000, 32'd3);
    repeat (32) @(negedge clk);
    chk("flushend_still_busy", 64'(busy3), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flushend_busy", 64'(busy3), 64'd0);
    chk("flushend_done", 64'(done3), 64'd0);
    chk("flushend_hilo", {hi3, lo3}, {mhi, mlo});

    // Flush in IDLE blocks MTLO and MULT
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd5; a = 32'h77;
    @(negedge clk);
    op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idleflush_busy", 64'(busy3), 64'd0);
    chk("idleflush_hilo", {hi3, lo3}, {mhi, mlo});

    // Start while busy is ignored
    issue(3'd3, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy3 && n < 100) begin n++; @(negedge clk); end
    chk("ignore_hilo", {hi3, lo3}, {32'd2, 32'd14});
    {mhi, mlo} = {32'd2, 32'd14};

    // Back-to-back: MTLO issued in the done cycle
    issue(3'd1, 32'd6, 32'd7);
    n = 0;
    while (busy3 && n < 50) begin n++; @(negedge clk); end
    chk("b2b_done", 64'(done3), 64'd1);
    chk("b2b_mul", {hi3, lo3}, 64'd42);
    start = 1'b1; op = 3'd5; a = 32'hAB;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_mtlo", 64'(lo3), 64'hAB);
    chk("b2b_done_clear", 64'(done3), 64'd0);
    {mhi, mlo} = {32'd0, 32'hAB};

    // Randomized ops against the reference model
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      if ($urandom_range(0, 5) == 0) rx = 32'h8000_0000;
      case ($urandom_range(0, 3))
        0:       ry = 32'd0;
        1:       ry = 32'($urandom_range(1, 20));
        2:       ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      run(ro, rx, ry, model(ro, rx, ry, {mhi, mlo}), $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Execute-stage HI/LO arithmetic unit, fed directly by the execute pipeline register: source operands after forwarding, plus a decoded operation.
- Performs MULT/MULTU with a fixed multi-cycle latency.
- Performs DIV/DIVU using a 32-iteration restoring divider.
- Handles MTHI/MTLO in a single cycle.
- Owns the architectural HI/LO registers.
- Asserts busy_o so the hazard unit can stall the pipeline, e.g. mfhi/mflo, or a new mult/div issued while the unit is busy.

Parameters:
MUL_LATENCY, 3, cycles from accept edge to HI/LO update for MULT/MULTU; legal range 1..15.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  execute stage holds a valid HI/LO op this cycle (already gated by stall_e/flush_e)
op_i  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
src_a_i  input  32  rs operand / dividend / MTHI-MTLO data
src_b_i  input  32  rt operand / divisor
flush_i  input  1  abort in-flight operation (exception/branch squash)
busy_o  output  1  multi-cycle operation in progress
done_o  output  1  one-cycle pulse, cycle after HI/LO updated by MULT/DIV op
hi_o  output  32  HI register
lo_o  output  32  LO register

Behaviour:
- Clock and reset: one clock is used. Reset is asynchronous and active-high.
- Reset values: state=IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, and all internal counters and operand registers = 0.
- Reset mid-operation aborts immediately. HI/LO are cleared.
- States: IDLE, MUL, DIV, FIX. busy_o is 1 in any state other than IDLE. busy_o is decoded from the registered state only, never from start_i.
- Accept: a request is accepted when start_i=1, state=IDLE and flush_i=0.
  - If start_i=1 while busy, the request is ignored. Issuing in that case is the hazard unit's responsibility.
- MTHI/MTLO: hi_o/lo_o take src_a_i at the accept edge. State stays IDLE and done_o is not pulsed.
- MULT/MULTU: the 64-bit product is captured at the accept edge, signed or unsigned per op. A counter is loaded with MUL_LATENCY-1.
  - State MUL decrements the counter. When the counter is 0, at that edge {hi_o,lo_o}=product and state returns to IDLE.
  - The update occurs at accept edge + MUL_LATENCY. busy_o is high for MUL_LATENCY cycles.
  - For MUL_LATENCY=1, the update occurs at the first edge after accept and busy_o is high for 1 cycle.
- DIV/DIVU:
  - Accept edge: operand magnitudes are latched. For signed ops this is the absolute value of each operand, and the quotient sign (a[31]^b[31]) and remainder sign (a[31]) are recorded.
  - State DIV: runs 32 restoring iterations, one quotient bit per cycle, MSB first. The remainder is 33 bits wide internally. An iteration counter runs 0..31.
  - After the 32nd iteration, state goes to FIX. FIX applies the signs; its edge writes LO=quotient, HI=remainder and returns to IDLE.
  - HI/LO update at accept edge + 33. busy_o is high for 33 cycles.
- Division rounding: the quotient truncates toward zero, and the remainder takes the sign of the dividend.
- Divide by zero, signed or unsigned: full latency is kept; the result is LO=0xFFFFFFFF, HI=src_a_i as latched.
- 0x80000000 / -1 (DIV): LO=0x80000000, HI=0. This falls out of the magnitude path with no special case.
- done_o: asserted for exactly one cycle following the HI/LO update edge of MULT/MULTU/DIV/DIVU.
- flush_i while busy: state returns to IDLE at the next edge. HI/LO are unchanged and done_o is not pulsed.
  - If flush_i coincides with the completion edge, flush wins and HI/LO are not written.
- flush_i with start_i in IDLE: the request is not accepted. This includes MTHI/MTLO, so HI/LO are not written.
- Back-to-back: a new start is accepted in the first cycle busy_o=0, i.e. the same cycle done_o is high.
- HI/LO outputs change only at completion or MT* edges. Intermediate values are never visible.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=5 -> busy_o high 3 cycles; at accept+3 HI=0xFFFFFFFF, LO=0xFFFFFFF1; done_o pulses once.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 3 cycles. The same operands with MULT -> HI=0, LO=1.
- DIV a=-7, b=2 -> busy_o high 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=100, b=0 -> after 33 cycles LO=0xFFFFFFFF, HI=100. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0x1234 via MTHI, start DIV, assert flush_i at cycle 10 -> busy_o low next cycle, HI=0x1234, no done_o. Repeat with flush on the completion edge -> same result.
- Assert rst_i mid-MULT (MUL_LATENCY=5, after 2 cycles) -> immediate busy_o=0, HI=LO=0. Back-to-back MULT then MTLO 0xAB issued in the done_o cycle -> LO=0xAB the next cycle.
